// File: rtl/pci_pkg.sv
// Shared definitions for the PCI burst phase controller.
package pci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    TURN = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Number of byte lanes on an AD bus of the given width.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/pci_be_lane_mask.sv
// Byte-lane qualification of one AD word: reads zero disabled lanes,
// writes pack enabled lanes toward lane 0. Also counts enabled lanes.
module pci_be_lane_mask
  import pci_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [be_width(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]           ad_in,
  input  logic                        rw,
  output logic [DATA_W-1:0]           data_q,
  output logic [3:0]                  byte_cnt
);

  localparam int unsigned BE_W = be_width(DATA_W);

  // Walk lanes low to high; k tracks the next free packed lane on writes.
  always_comb begin
    int unsigned k;
    data_q   = '0;
    byte_cnt = '0;
    k        = 0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        if (rw == RW_READ) begin
          data_q[i*8 +: 8] = ad_in[i*8 +: 8];
        end else begin
          data_q[k*8 +: 8] = ad_in[i*8 +: 8];
        end
        k        = k + 1;
        byte_cnt = byte_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pci_burst_phase_ctrl.sv
// Initiator-side PCI burst controller: address phase, N data phases counted
// on TRDY#, FRAME# released in the last phase, byte-lane qualified capture.
module pci_burst_phase_ctrl
  import pci_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        rw,
  input  logic [COUNT_W-1:0]          num_phases,
  input  logic [be_width(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]           ad_in,
  input  logic                        trdy_n,
  input  logic                        stop_n,
  output logic                        frame_n,
  output logic                        irdy_n,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [COUNT_W-1:0]          phases_left,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  output logic [3:0]                  byte_cnt
);

  state_t               state;
  logic                 rw_q;
  logic [DATA_W-1:0]    lane_word;
  logic [3:0]           lane_cnt;
  logic [COUNT_W-1:0]   left_dec;
  logic                 last_phase;

  pci_be_lane_mask #(
    .DATA_W (DATA_W)
  ) u_lane_mask (
    .be       (be),
    .ad_in    (ad_in),
    .rw       (rw_q),
    .data_q   (lane_word),
    .byte_cnt (lane_cnt)
  );

  // Remaining-phase arithmetic; the decrement saturates at zero.
  always_comb begin
    last_phase = (phases_left == COUNT_W'(1));
    left_dec   = (phases_left != '0) ? phases_left - COUNT_W'(1) : phases_left;
  end

  // Burst FSM with registered bus controls, counter and qualified data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rw_q        <= RW_READ;
      frame_n     <= 1'b1;
      irdy_n      <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      phases_left <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      byte_cnt    <= '0;
    end else begin
      done       <= 1'b0;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          frame_n <= 1'b1;
          irdy_n  <= 1'b1;
          if (start && (num_phases != '0)) begin
            state       <= ADDR;
            rw_q        <= rw;
            phases_left <= num_phases;
            frame_n     <= 1'b0;
            busy        <= 1'b1;
            aborted     <= 1'b0;
          end
        end
        ADDR: begin
          state   <= DATA;
          irdy_n  <= 1'b0;
          frame_n <= last_phase;
        end
        DATA: begin
          if (!trdy_n) begin
            phases_left <= left_dec;
            data_valid  <= 1'b1;
            data_out    <= lane_word;
            byte_cnt    <= lane_cnt;
          end
          // Last-phase completion takes priority over a same-cycle stop.
          if (!trdy_n && last_phase) begin
            state   <= TURN;
            frame_n <= 1'b1;
            irdy_n  <= 1'b1;
            done    <= 1'b1;
            aborted <= 1'b0;
          end else if (!stop_n) begin
            state   <= TURN;
            frame_n <= 1'b1;
            irdy_n  <= 1'b1;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (!trdy_n) begin
            frame_n <= (left_dec == COUNT_W'(1));
          end
        end
        TURN: begin
          state   <= IDLE;
          busy    <= 1'b0;
          frame_n <= 1'b1;
          irdy_n  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_burst_phase_ctrl.sv
// Self-checking bench for pci_burst_phase_ctrl (32-bit and 64-bit instances).
module tb_pci_burst_phase_ctrl;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [3:0]  num_phases = '0;
  logic [3:0]  be = '0;
  logic [31:0] ad_in = '0;
  logic        trdy_n = 1'b1;
  logic        stop_n = 1'b1;
  logic        frame_n, irdy_n, busy, done, aborted, data_valid;
  logic [3:0]  phases_left, byte_cnt;
  logic [31:0] data_out;

  logic        w_start = 1'b0;
  logic        w_rw = 1'b0;
  logic [3:0]  w_num = '0;
  logic [7:0]  w_be = '0;
  logic [63:0] w_ad = '0;
  logic        w_trdy_n = 1'b1;
  logic        w_stop_n = 1'b1;
  logic        w_frame_n, w_irdy_n, w_busy, w_done, w_aborted, w_valid;
  logic [3:0]  w_left, w_bc;
  logic [63:0] w_data;

  int   checks = 0;
  int   errors = 0;
  int   valid_seen = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pci_burst_phase_ctrl #(.DATA_W(32), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .num_phases(num_phases),
    .be(be), .ad_in(ad_in), .trdy_n(trdy_n), .stop_n(stop_n),
    .frame_n(frame_n), .irdy_n(irdy_n), .busy(busy), .done(done),
    .aborted(aborted), .phases_left(phases_left), .data_out(data_out),
    .data_valid(data_valid), .byte_cnt(byte_cnt)
  );

  pci_burst_phase_ctrl #(.DATA_W(64), .COUNT_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(w_start), .rw(w_rw), .num_phases(w_num),
    .be(w_be), .ad_in(w_ad), .trdy_n(w_trdy_n), .stop_n(w_stop_n),
    .frame_n(w_frame_n), .irdy_n(w_irdy_n), .busy(w_busy), .done(w_done),
    .aborted(w_aborted), .phases_left(w_left), .data_out(w_data),
    .data_valid(w_valid), .byte_cnt(w_bc)
  );

  // Reference lane qualification, built by shifting lanes into place.
  function automatic exp_t model(input logic wr, input logic [3:0] b, input logic [31:0] a);
    exp_t e;
    int   pos;
    e.d = '0;
    pos = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        if (wr) e.d = e.d | (((a >> (8*i)) & 32'hFF) << (8*pos));
        else    e.d = e.d | (a & (32'hFF << (8*i)));
        pos++;
      end
    end
    e.c = 4'(pos);
    return e;
  endfunction

  // Scoreboard: every data_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      valid_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data_out=%h byte_cnt=%0d, no phase pending", data_out, byte_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (data_out !== e.d || byte_cnt !== e.c) begin
          errors++;
          $display("FAIL qualified_data: got %h/%0d, expected %h/%0d", data_out, byte_cnt, e.d, e.c);
        end
      end
    end
  end

  task automatic run_burst(input logic rw_i, input logic [3:0] n, input int stop_ph,
                           input int wait_ph, input int wait_cyc, input logic hold_start,
                           input logic [3:0] be_i, input logic [31:0] ad_i);
    int   left = n;
    int   ph = 0;
    int   waited = 0;
    bit   ended = 0;
    bit   ab = 0;
    exp_t e;
    @(negedge clk);
    valid_seen = 0;
    start = 1'b1; num_phases = n; rw = rw_i; trdy_n = 1'b1; stop_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({frame_n, irdy_n, busy, done, phases_left} !== {1'b0, 1'b1, 1'b1, 1'b0, n}) begin
      errors++;
      $display("FAIL addr_phase: frame/irdy/busy/done/left=%b%b%b%b/%0d, expected 0110/%0d",
               frame_n, irdy_n, busy, done, phases_left, n);
    end
    start = hold_start;
    num_phases = 4'd7;
    for (int c = 0; c < 40 && !ended; c++) begin
      @(negedge clk);
      checks++;
      if ({irdy_n, frame_n, busy, done, phases_left} !==
          {1'b0, (left == 1), 1'b1, 1'b0, 4'(left)}) begin
        errors++;
        $display("FAIL data_phase: irdy/frame/busy/done/left=%b%b%b%b/%0d, expected 0%b10/%0d",
                 irdy_n, frame_n, busy, done, phases_left, (left == 1), left);
      end
      if (ph == wait_ph && waited < wait_cyc) begin
        trdy_n = 1'b1; stop_n = 1'b1;
        waited++;
      end else begin
        trdy_n = 1'b0;
        be     = be_i + 4'(ph);
        ad_in  = ad_i ^ (32'h11111111 * ph);
        stop_n = (ph == stop_ph) ? 1'b0 : 1'b1;
        e = model(rw_i, be, ad_in);
        sb.push_back(e);
        left--;
        if (left == 0) ended = 1;
        else if (ph == stop_ph) begin ended = 1; ab = 1; end
        ph++;
      end
    end
    if (!ended) begin
      errors++;
      $display("FAIL burst_timeout: burst never finished, %0d phases left", left);
    end
    @(negedge clk);
    trdy_n = 1'b1; stop_n = 1'b1; start = 1'b0;
    checks++;
    if ({done, aborted, frame_n, irdy_n, busy, phases_left} !==
        {1'b1, ab, 1'b1, 1'b1, 1'b1, 4'(left)}) begin
      errors++;
      $display("FAIL turn_phase: done/abort/frame/irdy/busy/left=%b%b%b%b%b/%0d, expected 1%b111/%0d",
               done, aborted, frame_n, irdy_n, busy, phases_left, ab, left);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, frame_n, irdy_n} !== 4'b0011 || sb.size() != 0 || valid_seen != ph) begin
      errors++;
      $display("FAIL burst_end: done/busy=%b%b pending=%0d valids=%0d, expected 00 0 %0d",
               done, busy, sb.size(), valid_seen, ph);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_n, irdy_n, busy, done, aborted, data_valid, phases_left, byte_cnt, data_out} !==
        {6'b110000, 4'd0, 4'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: frame/irdy/busy/done/abort/valid=%b%b%b%b%b%b left=%0d cnt=%0d data=%h",
               frame_n, irdy_n, busy, done, aborted, data_valid, phases_left, byte_cnt, data_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_burst3();
    run_burst(1'b0, 4'd3, -1, -1, 0, 1'b0, 4'b1111, 32'h12345678);
  endtask

  task automatic test_read_single();
    run_burst(1'b0, 4'd1, -1, -1, 0, 1'b0, 4'b0101, 32'hAABBCCDD);
  endtask

  task automatic test_write_pack();
    run_burst(1'b1, 4'd1, -1, -1, 0, 1'b0, 4'b1010, 32'hAABBCCDD);
    run_burst(1'b1, 4'd1, -1, -1, 0, 1'b0, 4'b0000, 32'hDEADBEEF);
    run_burst(1'b1, 4'd5, -1, -1, 0, 1'b0, 4'b0110, 32'h0F1E2D3C);
  endtask

  task automatic test_stop();
    run_burst(1'b0, 4'd4, 1, -1, 0, 1'b0, 4'b1100, 32'h55AA33CC);
    run_burst(1'b1, 4'd2, 1, -1, 0, 1'b0, 4'b0011, 32'h01020304);
  endtask

  task automatic test_wait_states();
    run_burst(1'b1, 4'd4, -1, 1, 3, 1'b0, 4'b1001, 32'hCAFEF00D);
  endtask

  task automatic test_back_to_back();
    run_burst(1'b0, 4'd2, -1, -1, 0, 1'b1, 4'b0111, 32'h89ABCDEF);
    run_burst(1'b1, 4'd15, -1, -1, 0, 1'b0, 4'b1110, 32'h13579BDF);
  endtask

  task automatic test_wide();
    @(negedge clk);
    w_start = 1'b1; w_num = 4'd1; w_rw = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    @(negedge clk);
    w_trdy_n = 1'b0; w_be = 8'h80; w_ad = 64'h1122334455667788;
    @(negedge clk);
    w_trdy_n = 1'b1;
    checks++;
    if ({w_valid, w_done, w_aborted, w_bc, w_data} !== {3'b110, 4'd1, 64'h11}) begin
      errors++;
      $display("FAIL wide_pack: valid/done/abort=%b%b%b cnt=%0d data=%h, expected 110 1 %h",
               w_valid, w_done, w_aborted, w_bc, w_data, 64'h11);
    end
  endtask

  task automatic test_async_reset_and_zero();
    exp_t e;
    @(negedge clk);
    start = 1'b1; num_phases = 4'd4; rw = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    trdy_n = 1'b0; be = 4'b1111; ad_in = 32'h76543210;
    e = model(1'b0, be, ad_in);
    sb.push_back(e);
    @(negedge clk);
    trdy_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_n, irdy_n, busy, done, aborted, data_valid, phases_left, byte_cnt, data_out} !==
        {6'b110000, 4'd0, 4'd0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: frame/irdy/busy/done/abort/valid=%b%b%b%b%b%b left=%0d cnt=%0d data=%h",
               frame_n, irdy_n, busy, done, aborted, data_valid, phases_left, byte_cnt, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    start = 1'b1; num_phases = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, frame_n} !== 3'b001) begin
        errors++;
        $display("FAIL zero_phases: busy/done/frame=%b%b%b, expected 001", busy, done, frame_n);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst3();
    test_read_single();
    test_write_pack();
    test_stop();
    test_wait_states();
    test_back_to_back();
    test_wide();
    test_async_reset_and_zero();
    run_burst(1'b0, 4'd2, -1, -1, 0, 1'b0, 4'b1000, 32'hFEDCBA98);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
